seg7_scan_monitor: RTL and testbench
====================================

// Module: seg7_scan_monitor
// PURPOSE
//   Receive-side counterpart of the multiplexed 4-digit 7-segment display driver.
//   Samples the active-low segment lines CA..CG and anode lines AN0..AN3 from the scanned display.
//   Decodes each lit digit back to BCD and holds the last value captured per digit.
//   Flags complete scan frames, blanked digits, illegal patterns and a stalled scan.
//   Used for on-board self-test and for closed-loop checking of the stopwatch display path.
// PARAMETERS
//   SETTLE_CYCLES   16         sync'd {AN,seg} must be unchanged this many clk cycles before capture (>=2)
//   TIMEOUT_CYCLES  2_000_000  clk cycles with no capture before stale asserts (20 ms at 100 MHz)
// PORTS
//   clk_100mhz   in   1  system clock, 100 MHz
//   rst          in   1  asynchronous, active-high reset
//   CA..CG       in   1  each; segment lines, active-low (0 = lit), asynchronous to clk
//   AN0..AN3     in   1  each; anode enables, active-low, asynchronous to clk
//   digit0..3    out  4  each; last captured value per digit (0-9, F = blank, E = illegal)
//   blank        out  4  bit n = digit n last captured as all-segments-off
//   err          out  4  bit n = digit n last captured with an undecodable pattern
//   frame_valid  out  1  one-cycle pulse: all four digits captured since the previous pulse
//   stale        out  1  no capture for TIMEOUT_CYCLES; sticky until the next capture
// BEHAVIOUR
//   Reset: all registers clear asynchronously on rst.
//     Reset values: digit0..3=0, blank=0, err=0, frame_valid=0, stale=0, seen mask=0,
//     settle counter=0, timeout counter=0, captured flag=0, synchronizers=all 1 (idle).
//   Synchronisation: all 11 inputs pass through a 2-flop synchronizer before any use.
//   Digit select: exactly one sync'd AN low gives the active index n.
//     Zero or more than one AN low is idle: no capture, and the settle counter clears.
//   Settle: the counter increments each cycle that sync'd {AN,seg} equals its previous-cycle value.
//     Any change clears the counter and the captured flag.
//     The counter saturates at SETTLE_CYCLES-1; its width is $clog2(SETTLE_CYCLES).
//   Capture: fires when not idle, the counter reaches SETTLE_CYCLES-1, and the captured flag is 0.
//     The flag then sets, so only one capture happens per anode dwell.
//     Outputs update on the clock edge after the capture condition.
//     Worst-case latency from input change to output update: 2 + SETTLE_CYCLES + 1 cycles.
//   Decode (CA..CG, MSB=CA):
//     0000001->0  1001111->1  0010010->2  0000110->3  0001111->7
//     1001100->4  0100100->5  0100000->6  0000000->8  0001100->9
//     1111111 -> value F, blank[n]=1, err[n]=0.
//     Any other pattern -> value E, err[n]=1, blank[n]=0.
//     Legal digits clear blank[n] and err[n].
//   Frame: a capture sets seen[n]; the scan order does not matter.
//     When a capture makes seen==4'b1111, frame_valid pulses for 1 cycle in the same cycle the digit updates.
//     In that same cycle seen clears to 0, including bit n.
//     Recapturing an already-seen digit only refreshes its value.
//   Stale: the timeout counter clears on every capture and otherwise increments, saturating at TIMEOUT_CYCLES.
//     stale=1 while the counter equals TIMEOUT_CYCLES.
//     A capture clears stale on the same edge the digit updates.
//   Reset mid-dwell: everything clears; a fresh full SETTLE window is required before the next capture.
// TESTING (SETTLE_CYCLES=16, TIMEOUT_CYCLES=1000 unless stated)
//   1 AN0 low, seg=0010010 held 100 cycles.
//     -> digit0=2 no later than cycle 19 after the input is applied; err=0, blank=0; exactly 1 capture.
//   2 Scan AN0..AN3 showing 1,2,3,4, 50-cycle dwell each, repeated twice.
//     -> frame_valid pulses exactly 2x, each on the AN3 capture; digit3..0 = 4,3,2,1.
//   3 AN1 low, seg toggles 0000110/0000000 every 8 cycles for 500 cycles -> no capture; digit1 stays 0.
//   4 AN0 & AN2 low together 100 cycles -> no capture.
//     Then AN2 low alone, seg=1111110 -> digit2=E, err=4'b0100.
//     Then AN2 low, seg=1111111 -> digit2=F, blank=4'b0100, err=0.
//   5 All AN high for 1000+ cycles -> stale=1.
//     Then AN3 low with seg=0001100 -> digit3=9 and stale=0 on the same edge.
//   6 rst pulsed mid-dwell, 10 cycles into a settled AN1 digit.
//     -> all outputs 0 immediately; the next capture occurs only after a full new settle window.

Source files
------------

// File: rtl/seg7_scan_monitor.sv
// seg7_scan_monitor
//   Watches the scanned 4-digit 7-segment display lines and turns them back
//   into per-digit BCD values. It is used for on-board self-test and for
//   closed-loop checking of the stopwatch display path.
//
//   A digit is captured once per anode dwell, after the synchronised
//   {AN,seg} bus has held still for SETTLE_CYCLES cycles.
//
// Ports
//   clk_100mhz         system clock
//   rst                asynchronous, active-high reset
//   CA..CG             segment lines, active-low (0 = lit), asynchronous
//   AN0..AN3           anode enables, active-low, asynchronous
//   digit0..digit3     last captured value per digit (0-9, F blank, E illegal)
//   blank / err        per-digit flags from the last capture of that digit
//   frame_valid        1-cycle pulse once all four digits have been captured
//   stale              no capture for TIMEOUT_CYCLES; cleared by next capture
module seg7_scan_monitor #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic       clk_100mhz,
  input  logic       rst,
  input  logic       CA,
  input  logic       CB,
  input  logic       CC,
  input  logic       CD,
  input  logic       CE,
  input  logic       CF,
  input  logic       CG,
  input  logic       AN0,
  input  logic       AN1,
  input  logic       AN2,
  input  logic       AN3,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] blank,
  output logic [3:0] err,
  output logic       frame_valid,
  output logic       stale
);

  localparam int NUM_DIGITS = 4;
  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT_CYCLES);

  // {AN3..AN0, CA..CG}; idle (all high) is the reset value of every stage
  logic [10:0] raw;
  logic [10:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;

  logic [SW-1:0] settle_q, settle_d;
  logic          captured_q, captured_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [NUM_DIGITS-1:0] seen_q, seen_d;
  logic                  fv_q, fv_d;
  logic [NUM_DIGITS-1:0][3:0] digit_q, digit_d;
  logic [NUM_DIGITS-1:0] blank_q, blank_d, err_q, err_d;

  logic [3:0] an;
  logic [6:0] seg;
  logic       idle, stable, capture;
  logic [1:0] sel_idx;
  logic [NUM_DIGITS-1:0] sel_oh, seen_nxt;
  logic [3:0] dec_val;
  logic       dec_blank, dec_err;

  assign raw = {AN3, AN2, AN1, AN0, CA, CB, CC, CD, CE, CF, CG};
  assign an  = sync2_q[10:7];
  assign seg = sync2_q[6:0];

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Exactly one anode low selects a digit; anything else is idle.
  always_comb begin
    idle    = 1'b0;
    sel_idx = 2'd0;
    sel_oh  = '0;
    unique case (an)
      4'b1110: begin sel_idx = 2'd0; sel_oh = 4'b0001; end
      4'b1101: begin sel_idx = 2'd1; sel_oh = 4'b0010; end
      4'b1011: begin sel_idx = 2'd2; sel_oh = 4'b0100; end
      4'b0111: begin sel_idx = 2'd3; sel_oh = 4'b1000; end
      default: idle = 1'b1;
    endcase
  end

  // Segment decode, bit order CA..CG (MSB = CA)
  always_comb begin
    dec_val   = 4'hE;
    dec_blank = 1'b0;
    dec_err   = 1'b0;
    case (seg)
      7'b0000001: dec_val = 4'd0;
      7'b1001111: dec_val = 4'd1;
      7'b0010010: dec_val = 4'd2;
      7'b0000110: dec_val = 4'd3;
      7'b1001100: dec_val = 4'd4;
      7'b0100100: dec_val = 4'd5;
      7'b0100000: dec_val = 4'd6;
      7'b0001111: dec_val = 4'd7;
      7'b0000000: dec_val = 4'd8;
      7'b0001100: dec_val = 4'd9;
      7'b1111111: begin dec_val = 4'hF; dec_blank = 1'b1; end
      default:    begin dec_val = 4'hE; dec_err   = 1'b1; end
    endcase
  end

  assign stable  = (sync2_q == prev_q);
  // captured_q blocks repeat captures while the same pattern keeps dwelling
  assign capture = !idle && (settle_q == SETTLE_MAX) && !captured_q;
  assign seen_nxt = seen_q | sel_oh;

  always_comb begin
    settle_d   = settle_q;
    captured_d = captured_q;
    tmo_d      = tmo_q;
    seen_d     = seen_q;
    fv_d       = 1'b0;
    digit_d    = digit_q;
    blank_d    = blank_q;
    err_d      = err_q;

    if (idle || !stable)          settle_d = '0;
    else if (settle_q != SETTLE_MAX) settle_d = settle_q + SW'(1);

    if (!stable)      captured_d = 1'b0;
    else if (capture) captured_d = 1'b1;

    if (capture)              tmo_d = '0;
    else if (tmo_q != TMO_MAX) tmo_d = tmo_q + TW'(1);

    if (capture) begin
      digit_d[sel_idx] = dec_val;
      blank_d[sel_idx] = dec_blank;
      err_d[sel_idx]   = dec_err;
      // Completing the set restarts collection from empty, this digit included
      if (seen_nxt == 4'b1111) begin
        fv_d   = 1'b1;
        seen_d = '0;
      end else begin
        seen_d = seen_nxt;
      end
    end
  end

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      prev_q     <= '1;
      settle_q   <= '0;
      captured_q <= 1'b0;
      tmo_q      <= '0;
      seen_q     <= '0;
      fv_q       <= 1'b0;
      digit_q    <= '0;
      blank_q    <= '0;
      err_q      <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      settle_q   <= settle_d;
      captured_q <= captured_d;
      tmo_q      <= tmo_d;
      seen_q     <= seen_d;
      fv_q       <= fv_d;
      digit_q    <= digit_d;
      blank_q    <= blank_d;
      err_q      <= err_d;
    end
  end

  assign digit0      = digit_q[0];
  assign digit1      = digit_q[1];
  assign digit2      = digit_q[2];
  assign digit3      = digit_q[3];
  assign blank       = blank_q;
  assign err         = err_q;
  assign frame_valid = fv_q;
  assign stale       = (tmo_q == TMO_MAX);

endmodule

// File: tb/tb_seg7_scan_monitor.sv
// Bench for seg7_scan_monitor: drives anode/segment dwells, pushes the
// expected capture of each dwell to a queue, pops and compares once the
// dwell has had time to be captured.
module tb_seg7_scan_monitor;
  localparam int SETTLE = 16;
  localparam int TMO    = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] seg = 7'h7F;
  logic [3:0] an  = 4'hF;
  logic [3:0] digit0, digit1, digit2, digit3, blank, err;
  logic frame_valid, stale;

  int n_checks = 0;
  int n_pass   = 0;
  int fv_cnt   = 0;
  int fv_good  = 0;

  typedef struct {
    int         idx;
    logic [3:0] val;
    logic       bl;
    logic       er;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  seg7_scan_monitor #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_100mhz(clk), .rst(rst),
    .CA(seg[6]), .CB(seg[5]), .CC(seg[4]), .CD(seg[3]),
    .CE(seg[2]), .CF(seg[1]), .CG(seg[0]),
    .AN0(an[0]), .AN1(an[1]), .AN2(an[2]), .AN3(an[3]),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .blank(blank), .err(err), .frame_valid(frame_valid), .stale(stale)
  );

  // Frame pulses; a pulse is "good" when it lands during the AN3 dwell showing 4
  always @(negedge clk) begin
    if (!rst && frame_valid) begin
      fv_cnt++;
      if (an == 4'b0111 && digit3 == 4'd4) fv_good++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic logic [6:0] enc(input int d);
    case (d)
      0: enc = 7'b0000001;  1: enc = 7'b1001111;
      2: enc = 7'b0010010;  3: enc = 7'b0000110;
      4: enc = 7'b1001100;  5: enc = 7'b0100100;
      6: enc = 7'b0100000;  7: enc = 7'b0001111;
      8: enc = 7'b0000000;  9: enc = 7'b0001100;
      default: enc = 7'b1111111;
    endcase
  endfunction

  function automatic int an_idx(input logic [3:0] a);
    case (a)
      4'b1110: an_idx = 0;
      4'b1101: an_idx = 1;
      4'b1011: an_idx = 2;
      4'b0111: an_idx = 3;
      default: an_idx = -1;
    endcase
  endfunction

  function automatic logic [3:0] get_dig(input int i);
    case (i)
      0: get_dig = digit0;
      1: get_dig = digit1;
      2: get_dig = digit2;
      3: get_dig = digit3;
      default: get_dig = 4'h0;
    endcase
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; an = 4'hF; seg = 7'h7F;
    cyc(3);
    rst = 1'b0;
    cyc(2);
  endtask

  // Drive one dwell; long single-anode dwells get an expected capture queued
  task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int n,
                       input logic [3:0] ev, input logic eb, input logic ee);
    exp_t e;
    an = a; seg = s;
    if (an_idx(a) >= 0 && n >= SETTLE + 3) begin
      e.idx = an_idx(a); e.val = ev; e.bl = eb; e.er = ee;
      exp_q.push_back(e);
    end
    cyc(n);
  endtask

  task automatic pop_exp(output exp_t e);
    e.idx = 0; e.val = 4'hx; e.bl = 1'bx; e.er = 1'bx;
    if (exp_q.size() > 0) e = exp_q.pop_front();
  endtask

  task automatic test_reset();
    cyc(2);
    n_checks++;
    if ({digit3, digit2, digit1, digit0} !== 16'h0) $display("FAIL reset_digits got %h want 0000", {digit3, digit2, digit1, digit0});
    else n_pass++;
    n_checks++;
    if ({blank, err, frame_valid, stale} !== 10'h0) $display("FAIL reset_flags got %b want 0", {blank, err, frame_valid, stale});
    else n_pass++;
    rst = 1'b0;
    cyc(2);
    n_checks++;
    if ({digit3, digit2, digit1, digit0, blank, err} !== 24'h0) $display("FAIL post_reset got %h want 0", {digit3, digit2, digit1, digit0, blank, err});
    else n_pass++;
  endtask

  task automatic test_single();
    exp_t e;
    int   k;
    an = 4'b1110; seg = enc(2);
    e.idx = 0; e.val = 4'd2; e.bl = 1'b0; e.er = 1'b0;
    exp_q.push_back(e);
    fv_cnt = 0;
    k = 0;
    while (k < SETTLE + 3 && digit0 !== 4'd2) begin
      cyc(1);
      k++;
    end
    pop_exp(e);
    n_checks++;
    if (digit0 !== e.val) $display("FAIL single_latency digit0 got %h want %h within %0d cycles", digit0, e.val, SETTLE + 3);
    else n_pass++;
    cyc(100 - k);
    n_checks++;
    if ({digit0, blank, err} !== {e.val, 4'b0000, 4'b0000}) $display("FAIL single_hold got %h/%b/%b want 2/0000/0000", digit0, blank, err);
    else n_pass++;
    n_checks++;
    if (fv_cnt !== 0) $display("FAIL single_no_frame got %0d pulses want 0", fv_cnt);
    else n_pass++;
  endtask

  task automatic test_scan();
    exp_t e;
    fv_cnt = 0; fv_good = 0;
    for (int r = 0; r < 2; r++) begin
      for (int d = 0; d < 4; d++) begin
        logic [3:0] a;
        a = 4'hF;
        a[d] = 1'b0;
        dwell(a, enc(d + 1), 50, 4'(d + 1), 1'b0, 1'b0);
        pop_exp(e);
        n_checks++;
        if ({get_dig(e.idx), blank[e.idx], err[e.idx]} !== {e.val, e.bl, e.er})
          $display("FAIL scan_digit%0d got %h/%b/%b want %h/%b/%b", e.idx, get_dig(e.idx), blank[e.idx], err[e.idx], e.val, e.bl, e.er);
        else n_pass++;
      end
    end
    n_checks++;
    if (fv_cnt !== 2) $display("FAIL scan_frame_count got %0d want 2", fv_cnt);
    else n_pass++;
    n_checks++;
    if (fv_good !== 2) $display("FAIL scan_frame_on_an3 got %0d want 2", fv_good);
    else n_pass++;
    n_checks++;
    if ({digit3, digit2, digit1, digit0} !== 16'h4321) $display("FAIL scan_final got %h want 4321", {digit3, digit2, digit1, digit0});
    else n_pass++;
  endtask

  task automatic test_unstable();
    int bad;
    do_reset();
    bad = 0;
    an = 4'b1101;
    for (int i = 0; i < 63; i++) begin
      seg = i[0] ? enc(8) : enc(3);
      for (int c = 0; c < 8; c++) begin
        cyc(1);
        if (digit1 !== 4'd0 || frame_valid !== 1'b0) bad++;
      end
    end
    n_checks++;
    if (bad !== 0) $display("FAIL unstable_no_capture got %0d bad cycles want 0 (digit1=%h)", bad, digit1);
    else n_pass++;
  endtask

  task automatic test_multi_and_illegal();
    exp_t e;
    dwell(4'b1010, enc(3), 100, 4'h0, 1'b0, 1'b0);
    n_checks++;
    if ({digit0, digit2, err, blank} !== 16'h0) $display("FAIL two_anodes got %h/%h/%b/%b want 0/0/0/0", digit0, digit2, err, blank);
    else n_pass++;
    dwell(4'b1011, 7'b1111110, 50, 4'hE, 1'b0, 1'b1);
    pop_exp(e);
    n_checks++;
    if ({digit2, err, blank} !== {e.val, 4'b0100, 4'b0000}) $display("FAIL illegal got %h/%b/%b want E/0100/0000", digit2, err, blank);
    else n_pass++;
    dwell(4'b1011, 7'b1111111, 50, 4'hF, 1'b1, 1'b0);
    pop_exp(e);
    n_checks++;
    if ({digit2, blank, err} !== {e.val, 4'b0100, 4'b0000}) $display("FAIL blank got %h/%b/%b want F/0100/0000", digit2, blank, err);
    else n_pass++;
  endtask

  task automatic test_stale();
    exp_t e;
    logic prev_stale;
    int   k;
    dwell(4'hF, 7'h7F, TMO + 20, 4'h0, 1'b0, 1'b0);
    n_checks++;
    if (stale !== 1'b1) $display("FAIL stale_set got %b want 1", stale);
    else n_pass++;
    an = 4'b0111; seg = enc(9);
    e.idx = 3; e.val = 4'd9; e.bl = 1'b0; e.er = 1'b0;
    exp_q.push_back(e);
    prev_stale = stale;
    k = 0;
    while (k < SETTLE + 5 && digit3 !== 4'd9) begin
      prev_stale = stale;
      cyc(1);
      k++;
    end
    pop_exp(e);
    n_checks++;
    if (digit3 !== e.val) $display("FAIL stale_capture digit3 got %h want %h", digit3, e.val);
    else n_pass++;
    n_checks++;
    if ({prev_stale, stale} !== 2'b10) $display("FAIL stale_clear_edge got before/after %b%b want 10", prev_stale, stale);
    else n_pass++;
  endtask

  task automatic test_reset_mid_dwell();
    exp_t e;
    do_reset();
    dwell(4'b1110, enc(8), 30, 4'd8, 1'b0, 1'b0);
    pop_exp(e);
    n_checks++;
    if (digit0 !== e.val) $display("FAIL pre_rst digit0 got %h want %h", digit0, e.val);
    else n_pass++;
    an = 4'b1101; seg = enc(6);
    cyc(10);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({digit3, digit2, digit1, digit0, blank, err, frame_valid, stale} !== 26'h0)
      $display("FAIL rst_async got %h want 0", {digit3, digit2, digit1, digit0, blank, err, frame_valid, stale});
    else n_pass++;
    cyc(2);
    rst = 1'b0;
    e.idx = 1; e.val = 4'd6; e.bl = 1'b0; e.er = 1'b0;
    exp_q.push_back(e);
    cyc(SETTLE + 1);
    n_checks++;
    if (digit1 !== 4'd0) $display("FAIL rst_early_capture digit1 got %h want 0", digit1);
    else n_pass++;
    cyc(2);
    pop_exp(e);
    n_checks++;
    if (digit1 !== e.val) $display("FAIL rst_recapture digit1 got %h want %h", digit1, e.val);
    else n_pass++;
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_scan();
    test_unstable();
    test_multi_and_illegal();
    test_stale();
    test_reset_mid_dwell();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
